mem_responder: RTL and testbench

Synchronous memory-side responder for the arbiter memory request protocol: accepts one request at a time (`req`/`addr`/`data`/`id`/`wr`), pulses `ack`, commits writes to an internal 2**AN x DN RAM, and returns read data tagged with the requester `id` on `valid`/`mem_data`/`mem_id`. It sits below the priority arbiter as the memory end of its interface. It serves as on-chip work RAM and as a bench model of slow memory, with configurable wait states and read latency.

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (arbiter side) and the memory responder.
interface mem_responder_if #(
  parameter int AN = 8,
  parameter int DN = 8,
  parameter int N  = 2
);
  logic          req;
  logic          wr;
  logic [AN-1:0] addr;
  logic [DN-1:0] data;
  logic [N-1:0]  id;
  logic          ack;
  logic          valid;
  logic [DN-1:0] mem_data;
  logic [N-1:0]  mem_id;

  modport master (
    output req, wr, addr, data, id,
    input  ack, valid, mem_data, mem_id
  );

  modport slave (
    input  req, wr, addr, data, id,
    output ack, valid, mem_data, mem_id
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, optional wait states, fixed-latency
// in-order read return tagged with the requester id.
module mem_responder #(
  parameter int AN   = 8,
  parameter int DN   = 8,
  parameter int N    = 2,
  parameter int WAIT = 0,
  parameter int LAT  = 1
) (
  input logic            clkSYS,
  input logic            reset,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          ack_q;
  logic          wr_q;
  logic [AN-1:0] addr_q;
  logic [DN-1:0] data_q;
  logic [N-1:0]  id_q;

  logic [DN-1:0] ram [2**AN];

  logic [LAT-1:0] pipe_v;
  logic [DN-1:0]  pipe_d  [LAT];
  logic [N-1:0]   pipe_id [LAT];

  // HOLD after ACK swallows a req the initiator keeps high one cycle too long.
  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ack_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      id_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            wr_q   <= bus.wr;
            addr_q <= bus.addr;
            data_q <= bus.data;
            id_q   <= bus.id;
            if (WAIT > 0) begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT - 1);
            end else begin
              state <= S_ACK;
              ack_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_ACK;
            ack_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACK:   state <= S_HOLD;
        S_HOLD:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset so contents survive it; a commit coinciding with reset is dropped.
  always_ff @(posedge clkSYS) begin
    if (!reset && state == S_ACK && wr_q) begin
      ram[addr_q] <= data_q;
    end
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_d[i]  <= '0;
        pipe_id[i] <= '0;
      end
    end else begin
      pipe_v[0]  <= (state == S_ACK) && !wr_q;
      pipe_d[0]  <= ram[addr_q];
      pipe_id[0] <= id_q;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_d[i]  <= pipe_d[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.valid    = pipe_v[LAT-1];
  assign bus.mem_data = pipe_d[LAT-1];
  assign bus.mem_id   = pipe_id[LAT-1];

endmodule

// File: tb/tb_mem_responder.sv
// Randomized plus directed bench for mem_responder, four instances with different
// WAIT/LAT settings, checked against a transaction-level expectation model.
module tb_mem_responder;

  localparam int AN = 8;
  localparam int DN = 8;
  localparam int N  = 2;
  localparam int NI = 4;

  function automatic int w_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      2:       return 0;
      default: return 5;
    endcase
  endfunction

  function automatic int l_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  typedef struct {
    int         k;
    int         cyc;
    bit         is_ack;
    logic [7:0] d;
    logic [1:0] id;
  } exp_t;

  logic          clkSYS = 1'b0;
  logic [NI-1:0] rst_d;
  logic [NI-1:0] req_d;
  logic [NI-1:0] wr_d;
  logic [7:0]    addr_d [NI];
  logic [7:0]    data_d [NI];
  logic [1:0]    id_d   [NI];
  logic [NI-1:0] ack_o;
  logic [NI-1:0] valid_o;
  logic [7:0]    mem_data_o [NI];
  logic [1:0]    mem_id_o   [NI];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q [$];
  logic [7:0] model_mem [NI][256];

  always #5 clkSYS = ~clkSYS;
  always @(posedge clkSYS) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    mem_responder_if #(.AN(AN), .DN(DN), .N(N)) bus ();
    assign bus.req       = req_d[g];
    assign bus.wr        = wr_d[g];
    assign bus.addr      = addr_d[g];
    assign bus.data      = data_d[g];
    assign bus.id        = id_d[g];
    assign ack_o[g]      = bus.ack;
    assign valid_o[g]    = bus.valid;
    assign mem_data_o[g] = bus.mem_data;
    assign mem_id_o[g]   = bus.mem_id;

    mem_responder #(.AN(AN), .DN(DN), .N(N), .WAIT(w_of(g)), .LAT(l_of(g))) dut (
      .clkSYS (clkSYS),
      .reset  (rst_d[g]),
      .bus    (bus)
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clkSYS);
  endtask

  // Called on a negedge: req is driven for this one cycle, expectations derived from
  // the timing rules (ack at +1+WAIT, read data at +1+WAIT+LAT).
  task automatic applyStimulus(input int k, input bit w, input logic [7:0] a,
                               input logic [7:0] d, input logic [1:0] i,
                               input bit exp_ack, input bit exp_ret);
    int   c0;
    exp_t e;
    c0 = cyc;
    req_d[k]  = 1'b1;
    wr_d[k]   = w;
    addr_d[k] = a;
    data_d[k] = d;
    id_d[k]   = i;
    if (exp_ack) begin
      e = '{k: k, cyc: c0 + 1 + w_of(k), is_ack: 1'b1, d: 8'h00, id: 2'd0};
      exp_q.push_back(e);
    end
    if (exp_ret) begin
      if (w) model_mem[k][a] = d;
      else begin
        e = '{k: k, cyc: c0 + 1 + w_of(k) + l_of(k), is_ack: 1'b0, d: model_mem[k][a], id: i};
        exp_q.push_back(e);
      end
    end
    @(negedge clkSYS);
    req_d[k]  = 1'b0;
    wr_d[k]   = 1'($urandom);
    addr_d[k] = 8'($urandom);
    data_d[k] = 8'($urandom);
    id_d[k]   = 2'($urandom);
  endtask

  task automatic randomPhase(input int k, input int nops);
    logic [7:0] a;
    for (int j = 0; j < 8; j++) begin
      applyStimulus(k, 1'b1, 8'h40 + 8'(j), 8'($urandom), 2'($urandom), 1'b1, 1'b1);
      idle(2 + w_of(k) + int'($urandom_range(0, 2)));
    end
    repeat (nops) begin
      a = 8'h40 + 8'($urandom_range(0, 7));
      applyStimulus(k, 1'($urandom), a, 8'($urandom), 2'($urandom), 1'b1, 1'b1);
      idle(2 + w_of(k) + int'($urandom_range(0, 2)));
    end
    idle(8);
  endtask

  // Every cycle, every instance: ack/valid must match exactly what the model scheduled.
  always @(negedge clkSYS) begin
    if (mon_en) begin
      for (int k = 0; k < NI; k++) begin
        bit         e_ack;
        bit         e_val;
        logic [7:0] e_d;
        logic [1:0] e_id;
        e_ack = 1'b0;
        e_val = 1'b0;
        e_d   = 8'h00;
        e_id  = 2'd0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (exp_q[i].k == k && exp_q[i].cyc == cyc) begin
            if (exp_q[i].is_ack) e_ack = 1'b1;
            else begin
              e_val = 1'b1;
              e_d   = exp_q[i].d;
              e_id  = exp_q[i].id;
            end
            exp_q.delete(i);
          end
        end
        checkOutput($sformatf("ack%0d", k), 32'(ack_o[k]), 32'(e_ack));
        checkOutput($sformatf("valid%0d", k), 32'(valid_o[k]), 32'(e_val));
        if (e_val) begin
          checkOutput($sformatf("mem_data%0d", k), 32'(mem_data_o[k]), 32'(e_d));
          checkOutput($sformatf("mem_id%0d", k), 32'(mem_id_o[k]), 32'(e_id));
        end
      end
    end
  end

  initial begin
    int   c0;
    exp_t e;
    rst_d = '1;
    req_d = '0;
    wr_d  = '0;
    for (int k = 0; k < NI; k++) begin
      addr_d[k] = 8'h00;
      data_d[k] = 8'h00;
      id_d[k]   = 2'd0;
    end
    idle(3);
    rst_d = '0;
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("rst_ack%0d", k), 32'(ack_o[k]), 32'd0);
      checkOutput($sformatf("rst_valid%0d", k), 32'(valid_o[k]), 32'd0);
      checkOutput($sformatf("rst_mem_data%0d", k), 32'(mem_data_o[k]), 32'd0);
      checkOutput($sformatf("rst_mem_id%0d", k), 32'(mem_id_o[k]), 32'd0);
    end
    mon_en = 1'b1;
    idle(1);

    $display("[TB] write then read, WAIT=0 LAT=1");
    applyStimulus(0, 1'b1, 8'h12, 8'hA5, 2'd2, 1'b1, 1'b1);
    idle(2);
    applyStimulus(0, 1'b0, 8'h12, 8'h00, 2'd1, 1'b1, 1'b1);
    idle(4);

    $display("[TB] held request, WAIT=0");
    c0 = cyc;
    req_d[0] = 1'b1;  wr_d[0] = 1'b0;  addr_d[0] = 8'h12;  id_d[0] = 2'd2;
    for (int j = 0; j < 3; j++) begin
      e = '{k: 0, cyc: c0 + 1 + 3 * j, is_ack: 1'b1, d: 8'h00, id: 2'd0};
      exp_q.push_back(e);
      e = '{k: 0, cyc: c0 + 2 + 3 * j, is_ack: 1'b0, d: model_mem[0][8'h12], id: 2'd2};
      exp_q.push_back(e);
    end
    idle(9);
    req_d[0] = 1'b0;
    idle(4);
    randomPhase(0, 25);

    $display("[TB] WAIT=3 LAT=2, addr changed during wait");
    applyStimulus(1, 1'b1, 8'h55, 8'h3C, 2'd0, 1'b1, 1'b1);
    idle(5);
    applyStimulus(1, 1'b0, 8'h55, 8'h00, 2'd3, 1'b1, 1'b1);
    idle(6);
    randomPhase(1, 20);

    $display("[TB] overlapping reads, WAIT=0 LAT=4");
    applyStimulus(2, 1'b1, 8'h01, 8'h11, 2'd1, 1'b1, 1'b1);
    idle(2);
    applyStimulus(2, 1'b1, 8'h02, 8'h22, 2'd2, 1'b1, 1'b1);
    idle(2);
    applyStimulus(2, 1'b0, 8'h01, 8'h00, 2'd0, 1'b1, 1'b1);
    idle(2);
    applyStimulus(2, 1'b0, 8'h02, 8'h00, 2'd3, 1'b1, 1'b1);
    idle(8);
    randomPhase(2, 25);

    $display("[TB] reset during wait states, WAIT=5");
    applyStimulus(3, 1'b1, 8'h30, 8'h01, 2'd0, 1'b1, 1'b1);
    idle(8);
    applyStimulus(3, 1'b1, 8'h30, 8'h7E, 2'd1, 1'b0, 1'b0);
    idle(2);
    rst_d[3] = 1'b1;
    idle(1);
    rst_d[3] = 1'b0;
    idle(3);
    applyStimulus(3, 1'b0, 8'h30, 8'h00, 2'd2, 1'b1, 1'b1);
    idle(12);

    $display("[TB] reset with read in flight, LAT=3");
    applyStimulus(3, 1'b0, 8'h30, 8'h00, 2'd3, 1'b1, 1'b0);
    idle(6);
    rst_d[3] = 1'b1;
    idle(1);
    rst_d[3] = 1'b0;
    checkOutput("flush_mem_data3", 32'(mem_data_o[3]), 32'd0);
    checkOutput("flush_mem_id3", 32'(mem_id_o[3]), 32'd0);
    idle(6);
    randomPhase(3, 15);

    idle(10);
    checkOutput("pending", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
